// File: rtl/spi_cmd_controller.sv
// SPI mode-0 command master for the 16-bit {R/W, addr[6:0], data[7:0]} frame.
// Shifts the frame out MSB first on copi, samples cipo on every sclk rise,
// then holds ncs low for one extra half-period before a CLK_DIV-cycle gap.
module spi_cmd_controller #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       ncs,
   output logic       copi,
   input  logic       cipo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  half_cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] tx_shift;
   logic [7:0]  rx_shift;
   logic        half_end;

   assign half_end = (half_cnt == HALF_LAST);

   // Frame sequencer: owns all SPI pins, handshake and capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         half_cnt  <= 8'd0;
         bit_cnt   <= 4'd0;
         tx_shift  <= 16'h0000;
         rx_shift  <= 8'h00;
         rx_data   <= 8'h00;
         cmd_ready <= 1'b0;
         done      <= 1'b0;
         sclk      <= 1'b0;
         ncs       <= 1'b1;
         copi      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               half_cnt  <= 8'd0;
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  // Latch the whole frame once; later input changes are ignored.
                  tx_shift  <= {cmd_write, cmd_addr, cmd_data};
                  copi      <= cmd_write;
                  ncs       <= 1'b0;
                  sclk      <= 1'b0;
                  bit_cnt   <= 4'd0;
                  cmd_ready <= 1'b0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (!half_end) begin
                  half_cnt <= half_cnt + 8'd1;
               end else begin
                  half_cnt <= 8'd0;
                  if (!sclk) begin
                     // Rising edge: capture peripheral data.
                     sclk     <= 1'b1;
                     rx_shift <= {rx_shift[6:0], cipo};
                  end else begin
                     // Falling edge: advance copi, or finish after bit 15.
                     sclk <= 1'b0;
                     if (bit_cnt == 4'd15) begin
                        state <= HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        tx_shift <= {tx_shift[14:0], 1'b0};
                        copi     <= tx_shift[14];
                     end
                  end
               end
            end
            HOLD: begin
               if (!half_end) begin
                  half_cnt <= half_cnt + 8'd1;
               end else begin
                  half_cnt <= 8'd0;
                  ncs      <= 1'b1;
                  copi     <= 1'b0;
                  done     <= 1'b1;
                  rx_data  <= rx_shift;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (!half_end) begin
                  half_cnt <= half_cnt + 8'd1;
               end else begin
                  half_cnt  <= 8'd0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               half_cnt  <= 8'd0;
               cmd_ready <= 1'b0;
               sclk      <= 1'b0;
               ncs       <= 1'b1;
               copi      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller with an expected-frame scoreboard.
module tb_spi_cmd_controller;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       done;
   logic [7:0] rx_data;
   logic       sclk;
   logic       ncs;
   logic       copi;
   logic       cipo;

   spi_cmd_controller #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .done(done), .rx_data(rx_data), .sclk(sclk), .ncs(ncs), .copi(copi),
      .cipo(cipo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_frame_q[$];
   logic [7:0]  exp_rx_q[$];

   int          mon_bits = 0;
   logic [15:0] mon_frame = 16'h0000;
   int          low_cnt = 0;
   int          high_cnt = 0;
   int          last_gap = 0;
   int          done_cnt = 0;
   int          acc_cnt = 0;
   logic        sclk_q = 1'b0;
   logic        ncs_q = 1'b1;
   logic [15:0] cipo_pat = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] frame, input logic [7:0] rx);
      exp_frame_q.push_back(frame);
      exp_rx_q.push_back(rx);
   endtask

   // Called at a negedge with cmd_valid high; returns just after the accepting posedge.
   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (cmd_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      cmd_write = w;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      wait_accept();
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (exp_frame_q.size() == 0 && exp_rx_q.size() == 0 && cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ncs"},   {31'd0, ncs},       32'd1);
      check({tag, "_sclk"},  {31'd0, sclk},      32'd0);
      check({tag, "_copi"},  {31'd0, copi},      32'd0);
      check({tag, "_done"},  {31'd0, done},      32'd0);
      check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
   endtask

   // Peripheral model: presents cipo_pat MSB first, updating after each sclk fall.
   initial begin
      cipo = 1'b0;
      forever begin
         @(negedge ncs);
         cipo = cipo_pat[15];
         for (int k = 14; k >= 0; k--) begin
            @(negedge sclk or posedge ncs);
            if (ncs) break;
            cipo = cipo_pat[k];
         end
         if (!ncs) @(negedge sclk or posedge ncs);
         cipo = 1'b0;
      end
   end

   // Accept counter, evaluated with the same pre-edge values the DUT sees.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst && cmd_valid && cmd_ready) acc_cnt++;
      end
   end

   // Bus monitor: rebuilds frames on sclk rises and scores them at ncs release.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_bits  = 0;
            mon_frame = 16'h0000;
            low_cnt   = 0;
         end else begin
            if (!ncs && ncs_q) begin
               last_gap  = high_cnt;
               high_cnt  = 0;
               mon_bits  = 0;
               mon_frame = 16'h0000;
               low_cnt   = 0;
            end
            if (!ncs) low_cnt++;
            else high_cnt++;
            if (sclk && !sclk_q && !ncs) begin
               mon_frame = {mon_frame[14:0], copi};
               mon_bits++;
            end
            if (ncs && !ncs_q) begin
               if (exp_frame_q.size() == 0) begin
                  check("unexpected_frame", {16'd0, mon_frame}, 32'hFFFF_FFFF);
               end else begin
                  check("frame", {16'd0, mon_frame}, {16'd0, exp_frame_q.pop_front()});
                  check("sclk_rises", mon_bits, 32'd16);
                  check("ncs_low_cycles", low_cnt, 33 * DIV);
               end
            end
            if (done) begin
               done_cnt++;
               if (exp_rx_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
               end
            end
         end
         sclk_q = sclk;
         ncs_q  = ncs;
      end
   end

   initial begin
      int acc0;
      bit hit;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 7'd0;
      cmd_data  = 8'd0;

      // Power-on reset state
      #1;
      check_reset_outputs("por");
      check("por_rx", {24'd0, rx_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("por_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset while idle
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("idle_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_rst_ready", {31'd0, cmd_ready}, 32'd1);

      // Single write frame 0x80F0
      push(16'h80F0, 8'h00);
      send(1'b1, 7'h00, 8'hF0);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
      check("done_cnt_t2", done_cnt, 32'd1);

      // Back-to-back with cmd_valid held high
      push(16'h82AA, 8'h00);
      send(1'b1, 7'h02, 8'hAA);
      @(negedge clk);
      cmd_addr = 7'h04;
      cmd_data = 8'h55;
      push(16'h8455, 8'h00);
      wait_accept();
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
      check("ncs_gap", last_gap, DIV + 1);
      check("done_cnt_t3", done_cnt, 32'd3);

      // Read frame with cipo data returned
      cipo_pat = 16'h00A5;
      push(16'h0100, 8'hA5);
      send(1'b0, 7'h01, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
      cipo_pat = 16'h0000;
      check("done_cnt_t4", done_cnt, 32'd4);

      // Abort mid-frame after 5 sclk rises, then a clean frame
      send(1'b1, 7'h03, 8'h3C);
      @(negedge clk);
      cmd_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (mon_bits == 5) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!hit) check("abort_wait_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("frame_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("frame_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("done_cnt_abort", done_cnt, 32'd4);
      push(16'h833C, 8'h00);
      send(1'b1, 7'h03, 8'h3C);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
      check("done_cnt_t5", done_cnt, 32'd5);

      // Input changes during a frame must not disturb it
      acc0 = acc_cnt;
      push(16'h8511, 8'h00);
      send(1'b1, 7'h05, 8'h11);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cmd_data  = 8'hEE;
         cmd_valid = ~cmd_valid;
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("single_accept", acc_cnt - acc0, 32'd1);
      check("done_cnt_t6", done_cnt, 32'd6);

      check("frames_left", exp_frame_q.size(), 32'd0);
      check("rx_left", exp_rx_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
